// File: rtl/pipe_pkg.sv
// Shared encodings, instruction layout, state enum and small decode helpers
// for the instruction fetch/decode/issue stage.
package pipe_pkg;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned PC_W       = $clog2(IMEM_DEPTH);
  localparam int unsigned INSTR_W    = 28;
  localparam int unsigned FUNC_W     = 4;
  localparam int unsigned REG_W      = 4;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned CNT_W      = 16;

  localparam logic [FUNC_W-1:0] F_ADD = 4'd0;
  localparam logic [FUNC_W-1:0] F_SUB = 4'd1;
  localparam logic [FUNC_W-1:0] F_MUL = 4'd2;
  localparam logic [FUNC_W-1:0] F_NEG = 4'd3;
  localparam logic [FUNC_W-1:0] F_MOV = 4'd4;
  localparam logic [FUNC_W-1:0] F_AND = 4'd5;
  localparam logic [FUNC_W-1:0] F_OR  = 4'd6;
  localparam logic [FUNC_W-1:0] F_XOR = 4'd7;
  localparam logic [FUNC_W-1:0] F_SLL = 4'd8;
  localparam logic [FUNC_W-1:0] F_CPY = 4'd9;
  localparam logic [FUNC_W-1:0] F_SRA = 4'd10;
  localparam logic [FUNC_W-1:0] F_SLA = 4'd11;
  localparam logic [FUNC_W-1:0] F_HLT = 4'd15;

  localparam logic [FUNC_W-1:0] F_ILL_LO = 4'd12;
  localparam logic [FUNC_W-1:0] F_ILL_HI = 4'd14;

  // Bit layout: func[27:24] rd[23:20] rs1[19:16] rs2[15:12] rsvd[11:8] addr[7:0]
  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [3:0]        rsvd;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  function automatic logic is_illegal(input logic [FUNC_W-1:0] f);
    return (f >= F_ILL_LO) && (f <= F_ILL_HI);
  endfunction

  function automatic logic uses_rs1(input logic [FUNC_W-1:0] f);
    logic r;
    case (f)
      F_ADD, F_SUB, F_MUL, F_AND, F_OR, F_XOR,
      F_NEG, F_SLL, F_SRA, F_SLA: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic uses_rs2(input logic [FUNC_W-1:0] f);
    logic r;
    case (f)
      F_ADD, F_SUB, F_MUL, F_AND, F_OR, F_XOR,
      F_MOV, F_CPY: r = 1'b1;
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Two-slot tracker of recently issued destinations plus source-use decode;
// flags a read-after-write hazard for the word currently being fetched.
module pipe_hazard
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              run,
  input  logic              issue,
  input  logic [FUNC_W-1:0] func,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  input  logic [REG_W-1:0]  rd,
  output logic              hazard
);

  logic             v0_q, v0_d, v1_q, v1_d;
  logic [REG_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic             rs1_hit, rs2_hit;

  // Slot 0 is the most recent issue slot; bubbles and idle cycles shift in invalid.
  always_comb begin
    v0_d  = 1'b0;
    rd0_d = '0;
    v1_d  = v0_q;
    rd1_d = rd0_q;
    if (clear) begin
      v1_d  = 1'b0;
      rd1_d = '0;
    end else if (run && issue) begin
      v0_d  = 1'b1;
      rd0_d = rd;
    end
  end

  always_comb begin
    rs1_hit = uses_rs1(func) && ((v0_q && (rd0_q == rs1)) || (v1_q && (rd1_q == rs1)));
    rs2_hit = uses_rs2(func) && ((v0_q && (rd0_q == rs2)) || (v1_q && (rd1_q == rs2)));
    hazard  = rs1_hit || rs2_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      rd0_q <= rd0_d;
      rd1_q <= rd1_d;
    end
  end

endmodule

// File: rtl/pipe_issue.sv
// Instruction fetch/decode/issue stage: program memory, PC sequencing,
// decode and RAW bubble insertion ahead of the register-fetch/ALU pipeline.
module pipe_issue
  import pipe_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  output logic [REG_W-1:0]   rs1,
  output logic [REG_W-1:0]   rs2,
  output logic [REG_W-1:0]   rd,
  output logic [FUNC_W-1:0]  func,
  output logic [ADDR_W-1:0]  addr,
  output logic               issue_valid,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [CNT_W-1:0]   issue_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  instr_t imem_q [IMEM_DEPTH];

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  instr_t            slot_d;
  logic              issue_valid_q, issue_valid_d;
  logic [REG_W-1:0]  rs1_q, rs2_q, rd_q;
  logic [FUNC_W-1:0] func_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q, done_q;

  instr_t w;
  logic   hazard;
  logic   issue_c;
  logic   clear_c;
  logic   imem_we_c;
  logic   unused_rsvd;

  assign w           = imem_q[pc_q];
  assign unused_rsvd = ^w.rsvd;

  pipe_hazard u_hazard (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_c),
    .run    (state_q == S_RUN),
    .issue  (issue_c),
    .func   (w.func),
    .rs1    (w.rs1),
    .rs2    (w.rs2),
    .rd     (w.rd),
    .hazard (hazard)
  );

  // Next-state, PC, counters and the issue slot for this cycle.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    illegal_d     = illegal_q;
    issue_cnt_d   = issue_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    slot_d        = '0;
    issue_valid_d = 1'b0;
    issue_c       = 1'b0;
    clear_c       = 1'b0;
    imem_we_c     = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        imem_we_c = prog_we;
        if (start) begin
          state_d     = S_RUN;
          pc_d        = start_pc;
          illegal_d   = 1'b0;
          issue_cnt_d = '0;
          stall_cnt_d = '0;
          clear_c     = 1'b1;
        end
      end
      S_RUN: begin
        if (w.func == F_HLT) begin
          state_d = S_HALT;
        end else if (is_illegal(w.func)) begin
          illegal_d = 1'b1;
          pc_d      = pc_q + PC_W'(1);
        end else if (hazard) begin
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
          issue_c       = 1'b1;
          issue_valid_d = 1'b1;
          slot_d        = w;
          pc_d          = pc_q + PC_W'(1);
          issue_cnt_d   = sat_inc(issue_cnt_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Program memory is deliberately outside reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (imem_we_c) begin
      imem_q[prog_addr] <= instr_t'(prog_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      illegal_q     <= 1'b0;
      issue_cnt_q   <= '0;
      stall_cnt_q   <= '0;
      issue_valid_q <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      func_q        <= '0;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      illegal_q     <= illegal_d;
      issue_cnt_q   <= issue_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      issue_valid_q <= issue_valid_d;
      rs1_q         <= slot_d.rs1;
      rs2_q         <= slot_d.rs2;
      rd_q          <= slot_d.rd;
      func_q        <= slot_d.func;
      addr_q        <= slot_d.addr;
      busy_q        <= (state_d == S_RUN);
      done_q        <= (state_d == S_HALT);
    end
  end

  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign func        = func_q;
  assign addr        = addr_q;
  assign issue_valid = issue_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign issue_cnt   = issue_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
